aes_vector_sequencer: RTL and testbench

Synthesizable, parametrised on-chip stimulus/check engine for the AES core. It holds DEPTH plaintext/key/expected-ciphertext triples and drives them into AES_top's AES_en/AES_data_in/AES_key_in interface one at a time. It waits for AES_data_out_valid, compares AES_data_out against the expected value, and accumulates pass/fail/timeout statistics. It sits beside AES_top for silicon bring-up and self-test, and can also be used as a reusable bench driver.

---
 rtl/aes_vector_sequencer.sv | 179 +++++++++++++++++
 tb/tb_aes_vector_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_vector_sequencer.sv
// On-chip stimulus/check engine that plays stored pt/key/expected triples into the AES core and tallies results.
// Optional AES_SEQ_LOOP_EN adds cfg_loop: wrap the vector list until a second start ends the run.
module aes_vector_sequencer #(
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2,
    parameter int CNT_W   = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              AES_clk,
    input  logic              AES_rst,
    input  logic              ld_we,
    input  logic [1:0]        ld_sel,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW:0]       cfg_num,
    input  logic              start,
`ifdef AES_SEQ_LOOP_EN
    input  logic              cfg_loop,
`endif
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  tmo_cnt,
    output logic              first_fail_vld,
    output logic [AW-1:0]     first_fail_idx
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FIN} state_t;

    state_t            state;
    logic [DATA_W-1:0] pt_mem  [DEPTH];
    logic [DATA_W-1:0] key_mem [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [AW-1:0]     idx, last;
    logic [WW-1:0]     wcnt;
    logic [GW-1:0]     gcnt;
    logic [AW:0]       num_c;
    logic [AW-1:0]     last_n;

`ifdef AES_SEQ_LOOP_EN
    logic loop_on, stop_req;
`else
    localparam logic loop_on  = 1'b0;
    localparam logic stop_req = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        num_c  = (cfg_num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_num;
        last_n = AW'(num_c - 1'b1);
    end

    // Vector memory is deliberately not reset; loads only land while idle.
    always_ff @(posedge AES_clk) begin
        if (ld_we && state == S_IDLE) begin
            case (ld_sel)
                2'd0:    pt_mem[ld_addr]  <= ld_data;
                2'd1:    key_mem[ld_addr] <= ld_data;
                2'd2:    exp_mem[ld_addr] <= ld_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state          <= S_IDLE;
            AES_en         <= 1'b0;
            AES_data_in    <= '0;
            AES_key_in     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            tmo_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            idx            <= '0;
            last           <= '0;
            wcnt           <= '0;
            gcnt           <= '0;
`ifdef AES_SEQ_LOOP_EN
            loop_on        <= 1'b0;
            stop_req       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef AES_SEQ_LOOP_EN
            if (start && busy && loop_on)
                stop_req <= 1'b1;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        tmo_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        idx            <= '0;
                        last           <= last_n;
                        busy           <= 1'b1;
                        state          <= (cfg_num == '0) ? S_FIN : S_ISSUE;
`ifdef AES_SEQ_LOOP_EN
                        loop_on        <= cfg_loop;
                        stop_req       <= 1'b0;
`endif
                    end
                end
                S_ISSUE: begin
                    AES_data_in <= pt_mem[idx];
                    AES_key_in  <= key_mem[idx];
                    AES_en      <= 1'b1;
                    wcnt        <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the timeout cycle still counts as a result.
                    if (AES_data_out_valid) begin
                        AES_en <= 1'b0;
                        gcnt   <= '0;
                        state  <= S_GAP;
                        if (AES_data_out == exp_mem[idx]) begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end else begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (!first_fail_vld) begin
                                first_fail_vld <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                    end else if (wcnt == WW'(TIMEOUT - 1)) begin
                        AES_en  <= 1'b0;
                        gcnt    <= '0;
                        state   <= S_GAP;
                        tmo_cnt <= sat_inc(tmo_cnt);
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        if (stop_req || (idx == last && !loop_on)) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= (idx == last) ? '0 : idx + 1'b1;
                            state <= S_ISSUE;
                        end
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_vector_sequencer.sv
// Randomised directed bench for aes_vector_sequencer with a behavioural AES core and a run-level reference model.
module tb_aes_vector_sequencer;
    localparam int DW = 128;
    localparam int TMO = 64;
    localparam int GP = 2;

    logic          AES_clk = 1'b0;
    logic          AES_rst = 1'b1;
    logic          ld_we = 1'b0;
    logic [1:0]    ld_sel = '0;
    logic [1:0]    ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [2:0]    cfg_num = '0;
    logic          start = 1'b0;
    logic          cfg_loop = 1'b0;
    logic          AES_en;
    logic [DW-1:0] AES_data_in, AES_key_in;
    logic [DW-1:0] AES_data_out = '0;
    logic          AES_data_out_valid = 1'b0;
    logic          busy, done, first_fail_vld;
    logic [15:0]   pass_cnt, fail_cnt, tmo_cnt;
    logic [1:0]    first_fail_idx;

    aes_vector_sequencer dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst), .ld_we(ld_we), .ld_sel(ld_sel),
        .ld_addr(ld_addr), .ld_data(ld_data), .cfg_num(cfg_num), .start(start),
`ifdef AES_SEQ_LOOP_EN
        .cfg_loop(cfg_loop),
`endif
        .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
        .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .tmo_cnt(tmo_cnt), .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
    );

    always #5 AES_clk = ~AES_clk;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] kat_pt  = 128'h00112233445566778899aabbccddeeff;
    logic [DW-1:0] kat_key = 128'h000102030405060708090a0b0c0d0e0f;
    logic [DW-1:0] kat_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [DW-1:0] pt_m [4], key_m [4], exp_m [4];

    // Core model: result appears in the lat-th cycle that AES_en is high.
    int lat = 11;
    bit never = 1'b0;
    bit stray = 1'b0;
    int hi = 0;

    function automatic logic [DW-1:0] core_f(input logic [DW-1:0] p, input logic [DW-1:0] k);
        if (p == kat_pt && k == kat_key) return kat_ct;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    always @(posedge AES_clk) begin
        #1;
        if (AES_en) hi++; else hi = 0;
        AES_data_out_valid = (stray && !AES_en) || (!never && AES_en && hi == lat);
        AES_data_out = AES_en ? core_f(AES_data_in, AES_key_in) : core_f(pt_m[0], key_m[0]);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int s, input logic [DW-1:0] p, input logic [DW-1:0] k, input logic [DW-1:0] e);
        @(negedge AES_clk);
        ld_we = 1'b1; ld_addr = 2'(s);
        ld_sel = 2'd0; ld_data = p;
        @(negedge AES_clk); ld_sel = 2'd1; ld_data = k;
        @(negedge AES_clk); ld_sel = 2'd2; ld_data = e;
        @(negedge AES_clk); ld_sel = 2'd3; ld_data = ~e;
        @(negedge AES_clk); ld_we = 1'b0;
        pt_m[s] = p; key_m[s] = k; exp_m[s] = e;
    endtask

    // One run: reference outcome derived from the stored vectors and the core latency.
    task automatic run(input string tag, input int ncfg, input int lt, input bit nv,
                       input bit poke, input bit sbusy);
        int n, w, ep, ef, et, efi, k, rises, r1, r2, en_hi;
        bit efv, en_prev;
        n = (ncfg > 4) ? 4 : ncfg;
        w = (nv || lt > TMO) ? TMO : lt;
        ep = 0; ef = 0; et = 0; efv = 0; efi = 0;
        for (int i = 0; i < n; i++) begin
            if (nv || lt > TMO) et++;
            else if (core_f(pt_m[i], key_m[i]) == exp_m[i]) ep++;
            else ef++;
            if (!efv && !(!(nv || lt > TMO) && core_f(pt_m[i], key_m[i]) == exp_m[i])) begin
                efv = 1; efi = i;
            end
        end
        lat = lt; never = nv;
        @(negedge AES_clk);
        cfg_num = 3'(ncfg); start = 1'b1;
        @(negedge AES_clk);
        start = 1'b0;
        k = 1; rises = 0; r1 = 0; r2 = 0; en_hi = 0; en_prev = 0;
        while (done !== 1'b1 && k < 3000) begin
            if (AES_en && !en_prev) begin
                rises++;
                if (rises == 1) r1 = k;
                if (rises == 2) r2 = k;
            end
            en_prev = AES_en;
            if (AES_en) en_hi++;
            ld_we = poke && k == 5;
            ld_sel = 2'd2; ld_addr = 2'd0; ld_data = ~exp_m[0];
            start = sbusy && k == 10;
            @(negedge AES_clk);
            k++;
        end
        ld_we = 1'b0; start = 1'b0;
        chk({tag, ".done_cycle"}, DW'(k), DW'(2 + n * (1 + w + GP)));
        chk({tag, ".pass"}, DW'(pass_cnt), DW'(ep));
        chk({tag, ".fail"}, DW'(fail_cnt), DW'(ef));
        chk({tag, ".tmo"}, DW'(tmo_cnt), DW'(et));
        chk({tag, ".ff_vld"}, DW'(first_fail_vld), DW'(efv));
        chk({tag, ".ff_idx"}, DW'(first_fail_idx), DW'(efi));
        chk({tag, ".en_cycles"}, DW'(en_hi), DW'(n * w));
        if (n >= 2) chk({tag, ".period"}, DW'(r2 - r1), DW'(1 + w + GP));
        @(negedge AES_clk);
        chk({tag, ".done_pulse"}, DW'(done), DW'(0));
        chk({tag, ".busy_after"}, DW'(busy), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] p, kk;
        int k;
        repeat (3) @(negedge AES_clk);
        chk("rst.en", DW'(AES_en), DW'(0));
        chk("rst.busy", DW'(busy), DW'(0));
        chk("rst.done", DW'(done), DW'(0));
        chk("rst.cnts", DW'({pass_cnt, fail_cnt, tmo_cnt}), DW'(0));
        chk("rst.ff", DW'({first_fail_vld, first_fail_idx}), DW'(0));
        chk("rst.data_in", AES_data_in, DW'(0));
        chk("rst.key_in", AES_key_in, DW'(0));
        AES_rst = 1'b0;

        load(0, kat_pt, kat_key, kat_ct);
        run("kat", 1, 11, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            kk = {$urandom, $urandom, $urandom, $urandom};
            load(i, p, kk, (i == 2) ? DW'(0) : core_f(p, kk));
        end
        stray = 1'b1;
        run("mismatch", 4, 11, 0, 0, 0);
        stray = 1'b0;

        run("timeout", 2, 11, 1, 0, 0);
        load(2, pt_m[2], key_m[2], core_f(pt_m[2], key_m[2]));
        run("coincide", 1, 64, 0, 0, 0);
        run("late", 1, 65, 0, 0, 0);
        run("zero", 0, 5, 0, 0, 0);
        run("clamp", 7, 3, 0, 0, 0);
        run("poke", 4, 5, 0, 1, 0);
        run("rerun", 4, 5, 0, 0, 0);
        run("start_busy", 3, 4, 0, 0, 1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                kk = {$urandom, $urandom, $urandom, $urandom};
                load(i, p, kk, ($urandom_range(0, 3) == 0) ? {$urandom, $urandom, $urandom, $urandom} : core_f(p, kk));
            end
            run($sformatf("rand%0d", r), $urandom_range(0, 7), $urandom_range(1, 70), 0, 0, 0);
        end

        // Reset in the middle of the second vector's wait.
        lat = 11; never = 0;
        @(negedge AES_clk); cfg_num = 3'd4; start = 1'b1;
        @(negedge AES_clk); start = 1'b0;
        k = 1;
        while (k < 20) begin @(negedge AES_clk); k++; end
        AES_rst = 1'b1;
        @(negedge AES_clk);
        chk("midrst.en", DW'(AES_en), DW'(0));
        chk("midrst.busy", DW'(busy), DW'(0));
        chk("midrst.cnts", DW'({pass_cnt, fail_cnt, tmo_cnt}), DW'(0));
        chk("midrst.data_in", AES_data_in, DW'(0));
        AES_rst = 1'b0;
        run("after_rst", 2, 6, 0, 0, 0);

`ifdef AES_SEQ_LOOP_EN
        for (int i = 0; i < 2; i++) load(i, pt_m[i], key_m[i], core_f(pt_m[i], key_m[i]));
        lat = 3; never = 0;
        begin
            int rises;
            bit en_prev;
            @(negedge AES_clk); cfg_num = 3'd2; cfg_loop = 1'b1; start = 1'b1;
            @(negedge AES_clk); start = 1'b0; cfg_loop = 1'b0;
            k = 1; rises = 0; en_prev = 0;
            while (done !== 1'b1 && k < 3000) begin
                if (AES_en && !en_prev) rises++;
                start = AES_en && !en_prev && rises == 6;
                en_prev = AES_en;
                @(negedge AES_clk);
                k++;
            end
            start = 1'b0;
            chk("loop.done", DW'(done), DW'(1));
            chk("loop.pass", DW'(pass_cnt), DW'(6));
            chk("loop.vectors", DW'(rises), DW'(6));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
